// File: rtl/press_event_decoder.sv
// Turns a debounced button level into one-cycle press, release, long-press and
// auto-repeat pulses, and keeps a saturating count of presses.
module press_event_decoder #(
    parameter int LONG_CYCLES   = 10,
    parameter int REPEAT_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             level_in,
    input  logic             clear_i,
    output logic             press_o,
    output logic             release_o,
    output logic             long_o,
    output logic             repeat_o,
    output logic             held_o,
    output logic [CNT_W-1:0] count_o,
    output logic             sat_o
);
    localparam int MAX_CYC = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int TW      = $clog2(MAX_CYC + 1);

    typedef enum logic [1:0] {IDLE, PRESSED, LONG} state_t;

    state_t           state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             level_q;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             long_q, long_d;
    logic             repeat_q, repeat_d;
    logic             held_q, held_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             sat_q, sat_d;
    logic             rise, fall;

    assign rise = level_in & ~level_q;
    assign fall = ~level_in & level_q;

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    press_d = 1'b1;
                    timer_d = TW'(1);
                    state_d = PRESSED;
                end
            end
            PRESSED: begin
                // Release wins over a long press landing on the same cycle
                if (fall) begin
                    release_d = 1'b1;
                    state_d   = IDLE;
                end else if (timer_q == TW'(LONG_CYCLES)) begin
                    long_d  = 1'b1;
                    timer_d = TW'(1);
                    state_d = LONG;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            LONG: begin
                if (fall) begin
                    release_d = 1'b1;
                    state_d   = IDLE;
                end else if (timer_q == TW'(REPEAT_CYCLES)) begin
                    repeat_d = 1'b1;
                    timer_d  = TW'(1);
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        held_d = (state_d != IDLE);
    end

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = press_d ? CNT_W'(1) : '0;
        end else if (press_d && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
        sat_d = &count_d;
    end

    // level_q resets high so a button held through reset must be released first
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q   <= 1'b1;
            state_q   <= IDLE;
            timer_q   <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            held_q    <= 1'b0;
            count_q   <= '0;
            sat_q     <= 1'b0;
        end else begin
            level_q   <= level_in;
            state_q   <= state_d;
            timer_q   <= timer_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
            held_q    <= held_d;
            count_q   <= count_d;
            sat_q     <= sat_d;
        end
    end

    assign press_o   = press_q;
    assign release_o = release_q;
    assign long_o    = long_q;
    assign repeat_o  = repeat_q;
    assign held_o    = held_q;
    assign count_o   = count_q;
    assign sat_o     = sat_q;
endmodule

// File: tb/tb_press_event_decoder.sv
// Scoreboard bench: each stimulus pushes its expected pulses (kind, cycle);
// a negedge monitor pops and compares every pulse the decoder emits.
module tb_press_event_decoder;
    localparam int LONG = 10;
    localparam int REP  = 4;
    localparam int CW   = 4;

    localparam int K_PRESS   = 0;
    localparam int K_RELEASE = 1;
    localparam int K_LONG    = 2;
    localparam int K_REPEAT  = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          level_in = 1'b0;
    logic          clear_i = 1'b0;
    logic          press_o, release_o, long_o, repeat_o, held_o, sat_o;
    logic [CW-1:0] count_o;

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    ev_t sb[$];
    int  cyc = 0;
    int  vectors = 0;
    int  miscompares = 0;
    int  exp_count = 0;

    press_event_decoder #(
        .LONG_CYCLES  (LONG),
        .REPEAT_CYCLES(REP),
        .CNT_W        (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .level_in (level_in),
        .clear_i  (clear_i),
        .press_o  (press_o),
        .release_o(release_o),
        .long_o   (long_o),
        .repeat_o (repeat_o),
        .held_o   (held_o),
        .count_o  (count_o),
        .sat_o    (sat_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input int at);
        ev_t e;
        e.kind = kind;
        e.cyc  = at;
        sb.push_back(e);
    endtask

    task automatic expect_pulse(input int kind);
        ev_t e;
        if (sb.size() == 0) begin
            check($sformatf("spurious_pulse_kind%0d", kind), sb.size(), 1);
        end else begin
            e = sb.pop_front();
            check("pulse_kind", kind, e.kind);
            check("pulse_cycle", cyc, e.cyc);
            $display("pulse kind=%0d at cycle %0d (expected kind=%0d at %0d)", kind, cyc, e.kind, e.cyc);
        end
    endtask

    always @(negedge clk) begin
        if (press_o)   expect_pulse(K_PRESS);
        if (release_o) expect_pulse(K_RELEASE);
        if (long_o)    expect_pulse(K_LONG);
        if (repeat_o)  expect_pulse(K_REPEAT);
    end

    // Must be called at a negedge; holds level_in high for h sampled edges.
    task automatic press_hold(input int h);
        int p;
        p = cyc + 1;
        push(K_PRESS, p);
        if (h > LONG) begin
            push(K_LONG, p + LONG);
            for (int t = p + LONG + REP; t < p + h; t += REP) push(K_REPEAT, t);
        end
        push(K_RELEASE, p + h);
        if (exp_count < (1 << CW) - 1) exp_count++;
        level_in = 1'b1;
        @(negedge clk);
        check("held_after_press", held_o, 1);
        repeat (h - 1) @(negedge clk);
        level_in = 1'b0;
        repeat (3) @(negedge clk);
        check("held_after_release", held_o, 0);
        check("count", count_o, exp_count);
        check("sat", sat_o, (exp_count == (1 << CW) - 1));
    endtask

    initial begin
        int p;
        // Reset with level low
        repeat (2) @(negedge clk);
        check("rst_pulses", {press_o, release_o, long_o, repeat_o}, 0);
        check("rst_held", held_o, 0);
        check("rst_count", count_o, 0);
        check("rst_sat", sat_o, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        press_hold(3);
        press_hold(25);
        press_hold(10);

        // Drive into saturation
        for (int i = 0; i < 17; i++) press_hold(1);

        // Clear coinciding with a press
        p = cyc + 1;
        push(K_PRESS, p);
        push(K_RELEASE, p + 1);
        level_in = 1'b1;
        clear_i  = 1'b1;
        @(negedge clk);
        clear_i  = 1'b0;
        level_in = 1'b0;
        exp_count = 1;
        check("clear_press_count", count_o, exp_count);
        check("clear_press_sat", sat_o, 0);
        repeat (3) @(negedge clk);

        // Clear alone
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        exp_count = 0;
        check("clear_count", count_o, exp_count);
        check("clear_sat", sat_o, 0);

        // Async reset in the middle of a hold
        press_hold(2);
        p = cyc + 1;
        push(K_PRESS, p);
        level_in = 1'b1;
        repeat (5) @(negedge clk);
        check("midhold_held", held_o, 1);
        #2 rst = 1'b1;
        #1;
        exp_count = 0;
        check("async_rst_pulses", {press_o, release_o, long_o, repeat_o}, 0);
        check("async_rst_held", held_o, 0);
        check("async_rst_count", count_o, exp_count);
        check("async_rst_sat", sat_o, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        check("held_through_rst", held_o, 0);
        level_in = 1'b0;
        repeat (3) @(negedge clk);
        press_hold(2);

        // Fall while idle after reset with level high
        #2 rst = 1'b1;
        level_in = 1'b1;
        exp_count = 0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        level_in = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_fall_held", held_o, 0);
        check("idle_fall_count", count_o, exp_count);

        repeat (4) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/press_event_decoder.md
# press_event_decoder

Consumes the clean, debounced button level produced by the existing debouncer and turns it into discrete user events. It emits one-cycle press, release, long-press and auto-repeat pulses and keeps a saturating count of presses (coin drops for the piggy bank). It sits between the debouncer output and the display/control logic inside the Tiny Tapeout top.

## Interface
Parameters:
- LONG_CYCLES, default 10, clock cycles from the press pulse to the long-press pulse (≥ 2).
- REPEAT_CYCLES, default 4, period of auto-repeat pulses after a long press (≥ 1).
- CNT_W, default 8, width of the press counter.

Ports:
- clk  in  1  Single clock; all logic on its rising edge.
- rst  in  1  Reset, asynchronous and active-high.
- level_in  in  1  Debounced button level, synchronous to clk; 1 = pressed.
- clear_i  in  1  Synchronous clear of count_o and sat_o.
- press_o  out  1  One-cycle pulse on a press.
- release_o  out  1  One-cycle pulse on a release.
- long_o  out  1  One-cycle pulse when the hold reaches LONG_CYCLES.
- repeat_o  out  1  One-cycle pulse every REPEAT_CYCLES while a long hold continues.
- held_o  out  1  High while in PRESSED or LONG.
- count_o  out  CNT_W  Number of presses, saturating.
- sat_o  out  1  High when count_o = 2^CNT_W−1.

## Operation
- Internal registers: level_q (previous level_in), state, and timer, which is wide enough for max(LONG_CYCLES, REPEAT_CYCLES).
- All outputs are registered. Reset values: level_q=1, state=IDLE, timer=0, and every output 0.
- Resetting level_q to 1 means a button held through reset is ignored until it is released and pressed again.
- Rise = level_in & ~level_q. Fall = ~level_in & level_q.
- FSM states are IDLE, PRESSED and LONG.
- IDLE:
  - On rise: press_o=1, timer=1, go to PRESSED.
  - Fall in IDLE produces nothing.
- PRESSED:
  - On fall: release_o=1, go to IDLE.
  - Else if timer = LONG_CYCLES: long_o=1, timer=1, go to LONG.
  - Else timer increments.
- LONG:
  - On fall: release_o=1, go to IDLE.
  - Else if timer = REPEAT_CYCLES: repeat_o=1, timer=1.
  - Else timer increments.
- Fall takes priority over long and repeat in the same cycle. Neither long_o nor repeat_o fires on the release cycle.
- held_o = (state ≠ IDLE), registered.
- Counter:
  - count_o increments by 1 in the same cycle press_o is asserted, unless already at 2^CNT_W−1 (saturates, no wrap).
  - sat_o = (count_o == all ones).
  - When clear_i coincides with a press, count_o becomes 1. clear_i alone gives count_o=0 and sat_o=0.
- Async rst mid-hold forces IDLE immediately with no release_o. The held level is then ignored, per the level_q rule.

## Timing
- Press latency: level_in first sampled 1 at edge k, so press_o is high in cycle k+1 (one register stage), with held_o rising in the same cycle.
- long_o is high exactly LONG_CYCLES cycles after press_o, if level_in stays 1 throughout.
- The first repeat_o is REPEAT_CYCLES cycles after long_o, then every REPEAT_CYCLES cycles.
- Release latency: level_in first sampled 0 at edge m, so release_o is high in cycle m+1 and held_o falls in the same cycle.
- A one-cycle-high level_in gives press_o at k+1 and release_o at k+2.
- Pulses never exceed one cycle. press_o and release_o are never high together.

## Test plan
(LONG_CYCLES=10, REPEAT_CYCLES=4, CNT_W=4)
- Reset with level_in=0, then a 3-cycle press → press_o one cycle after the rise, release_o 3 cycles later, no long_o, count_o=1.
- Hold for 25 cycles → long_o 10 cycles after press_o, repeat_o at +14, +18 and +22, release_o after the fall, count_o increments once.
- Release on exactly the cycle long_o would fire (hold 10 cycles) → release_o=1 and long_o never asserted.
- 17 short presses → count_o stops at 15 with sat_o=1. Then clear_i concurrent with a press → count_o=1, sat_o=0.
- Assert rst mid-hold with level_in kept at 1 → all outputs 0 immediately, no press_o until level_in goes 0 then 1 again.
- Fall while IDLE (right after reset with level_in=1 then 0) → no release_o, held_o stays 0.
